sprite_sram_reader: RTL and testbench

SPRITE_SRAM_READER -- requirements
Module: sprite_sram_reader

---
 rtl/sprite_sram_reader_pkg.sv | 37 +++
 rtl/sprite_sram_reader.sv | 161 ++++++++++++++++
 tb/tb_sprite_sram_reader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_sram_reader_pkg.sv
// -----------------------------------------------------------------------------
// Numbers: shared types and constants for sprite_sram_reader.
//   state_t          - reader FSM states
//   PIXEL_*_OFFSET   - halfword offset of each half of a pixel in SRAM
//   MISS_LATENCY     - accept-to-response cycles when SRAM is read
//   HIT_LATENCY      - accept-to-response cycles on a cache hit
//   hw_addr()        - builds the SRAM halfword address for a pixel half
// -----------------------------------------------------------------------------
package Numbers;

    localparam int PIX_ADDR_W = 19;  // pixel index width actually used
    localparam int HW_ADDR_W  = 20;  // SRAM halfword address width
    localparam int PIXEL_W    = 24;  // {R,G,B}
    localparam int SRAM_DQ_W  = 16;

    // Sprite RAM layout: each pixel occupies two consecutive halfwords.
    localparam logic PIXEL_HI_OFFSET = 1'b0;  // {R,G}
    localparam logic PIXEL_LO_OFFSET = 1'b1;  // {8'h00,B}

    localparam int MISS_LATENCY = 3;
    localparam int HIT_LATENCY  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_HI = 2'd1,
        RD_LO = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [HW_ADDR_W-1:0] hw_addr(
        input logic [PIX_ADDR_W-1:0] pix,
        input logic                  offset
    );
        return {pix, offset};
    endfunction

endpackage

// File: rtl/sprite_sram_reader.sv
// -----------------------------------------------------------------------------
// sprite_sram_reader: fetches one 24-bit pixel from a 16-bit asynchronous SRAM
// as two halfword reads ({R,G} then {8'h00,B}) and returns it with a
// one-cycle Rsp_Valid pulse.
//
// Optional build macro: SPRITE_CACHE_EN
//   When defined, a one-entry cache remembers the last pixel read from SRAM;
//   a repeated request for the same pixel responds one cycle after accept
//   without touching the SRAM.
//
// Ports:
//   Clk, Reset       clock, synchronous active-high reset
//   Req_Valid        request strobe (only sampled in IDLE)
//   Req_Addr[19:0]   pixel index; bit 19 ignored
//   Req_Ready        high while idle
//   Rsp_Valid        one-cycle pulse qualifying Data_Out
//   Data_Out[23:0]   pixel {R,G,B}, held between responses
//   Transparent      Data_Out == 0, registered alongside Data_Out
//   SRAM_ADDR[19:0]  halfword address (0 when not reading)
//   SRAM_DQ[15:0]    SRAM read data
//   SRAM_*_N         active-low SRAM controls; WE_N tied high (read-only)
//
// States:
//   IDLE  | waiting for a request, Req_Ready high
//   RD_HI | SRAM driven with {addr,0}; {R,G} captured at end of cycle
//   RD_LO | SRAM driven with {addr,1}; B captured at end of cycle
//   DONE  | Rsp_Valid high with the new Data_Out / Transparent
// -----------------------------------------------------------------------------
module sprite_sram_reader
    import Numbers::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Req_Valid,
    input  logic [HW_ADDR_W-1:0] Req_Addr,
    output logic                 Req_Ready,
    output logic                 Rsp_Valid,
    output logic [PIXEL_W-1:0]   Data_Out,
    output logic                 Transparent,
    output logic [HW_ADDR_W-1:0] SRAM_ADDR,
    input  logic [SRAM_DQ_W-1:0] SRAM_DQ,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_OE_N,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N
);

    state_t                  state;
    logic [PIX_ADDR_W-1:0]   addr;
    logic [SRAM_DQ_W-1:0]    hi_reg;
    logic [7:0]              lo_reg;
    logic                    sram_en_n;
    logic [PIXEL_W-1:0]      pixel_next;

    // Bit 19 of the request address is not part of the pixel index.
    logic unused_addr_msb;
    assign unused_addr_msb = Req_Addr[HW_ADDR_W-1];

    // Pixel completed at the end of RD_LO: captured high half plus the low
    // byte currently on the bus (the upper byte of that halfword is padding).
    assign pixel_next = {hi_reg, SRAM_DQ[7:0]};

    // All read-enables move together; the SRAM is never written.
    assign SRAM_CE_N = sram_en_n;
    assign SRAM_OE_N = sram_en_n;
    assign SRAM_UB_N = sram_en_n;
    assign SRAM_LB_N = sram_en_n;
    assign SRAM_WE_N = 1'b1;

`ifdef SPRITE_CACHE_EN
    logic [PIX_ADDR_W-1:0] cache_addr;
    logic [PIXEL_W-1:0]    cache_data;
    logic                  cache_valid;
    logic                  cache_hit;

    assign cache_hit = cache_valid && (Req_Addr[PIX_ADDR_W-1:0] == cache_addr);
`else
    // lo_reg only feeds the cache fill; without the cache nothing reads it.
    logic [7:0] unused_lo;
    assign unused_lo = lo_reg;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            addr        <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            Req_Ready   <= 1'b1;
            Rsp_Valid   <= 1'b0;
            Data_Out    <= '0;
            Transparent <= 1'b1;
            SRAM_ADDR   <= '0;
            sram_en_n   <= 1'b1;
`ifdef SPRITE_CACHE_EN
            cache_addr  <= '0;
            cache_data  <= '0;
            cache_valid <= 1'b0;
`endif
        end else begin
            Rsp_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req_Valid) begin
                        addr      <= Req_Addr[PIX_ADDR_W-1:0];
                        Req_Ready <= 1'b0;
`ifdef SPRITE_CACHE_EN
                        if (cache_hit) begin
                            state       <= DONE;
                            Rsp_Valid   <= 1'b1;
                            Data_Out    <= cache_data;
                            Transparent <= (cache_data == '0);
                        end else begin
                            state     <= RD_HI;
                            SRAM_ADDR <= hw_addr(Req_Addr[PIX_ADDR_W-1:0], PIXEL_HI_OFFSET);
                            sram_en_n <= 1'b0;
                        end
`else
                        state     <= RD_HI;
                        SRAM_ADDR <= hw_addr(Req_Addr[PIX_ADDR_W-1:0], PIXEL_HI_OFFSET);
                        sram_en_n <= 1'b0;
`endif
                    end
                end
                RD_HI: begin
                    hi_reg    <= SRAM_DQ;
                    SRAM_ADDR <= hw_addr(addr, PIXEL_LO_OFFSET);
                    state     <= RD_LO;
                end
                RD_LO: begin
                    lo_reg      <= SRAM_DQ[7:0];
                    Data_Out    <= pixel_next;
                    Transparent <= (pixel_next == '0);
                    Rsp_Valid   <= 1'b1;
                    SRAM_ADDR   <= '0;
                    sram_en_n   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
`ifdef SPRITE_CACHE_EN
                    // On a hit hi/lo still hold the last miss, which is what
                    // the cache already contains, so refilling is harmless.
                    cache_addr  <= addr;
                    cache_data  <= {hi_reg, lo_reg};
                    cache_valid <= 1'b1;
`endif
                    Req_Ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    Req_Ready <= 1'b1;
                    SRAM_ADDR <= '0;
                    sram_en_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_sram_reader.sv
// Testbench for sprite_sram_reader: directed requests, scoreboard of expected
// pixels/latencies and SRAM address sequences, checked by a negedge monitor.
module tb_sprite_sram_reader;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req_Valid;
    logic [19:0] Req_Addr;
    logic        Req_Ready;
    logic        Rsp_Valid;
    logic [23:0] Data_Out;
    logic        Transparent;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

    sprite_sram_reader dut (
        .Clk(Clk), .Reset(Reset),
        .Req_Valid(Req_Valid), .Req_Addr(Req_Addr), .Req_Ready(Req_Ready),
        .Rsp_Valid(Rsp_Valid), .Data_Out(Data_Out), .Transparent(Transparent),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    always #5 Clk = ~Clk;

    // Asynchronous SRAM model; returns junk when not enabled.
    function automatic logic [15:0] sram_read(input logic [19:0] a);
        case (a)
            20'h00002: return 16'h1122;
            20'h00003: return 16'h0044;
            20'h00004: return 16'h5566;
            20'h00005: return 16'h0077;
            20'h00006: return 16'h8899;
            20'h00007: return 16'h00AA;
            20'h00008: return 16'h0102;
            20'h00009: return 16'hFF03;
            20'h00020: return 16'hF8A0;
            20'h00021: return 16'h0033;
            20'hFFFFE: return 16'hABCD;
            20'hFFFFF: return 16'h00EF;
            default:   return 16'h0000;
        endcase
    endfunction

    always_comb begin
        SRAM_DQ = 16'hDEAD;
        if (!SRAM_CE_N && !SRAM_OE_N) SRAM_DQ = sram_read(SRAM_ADDR);
    end

    typedef struct {
        logic [23:0] data;
        logic        transp;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    logic [19:0] sram_q[$];
    int          accq[$];
    int          acc_log[$];
    int          rsp_log[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 0;
    bit busy     = 0;
    bit skip     = 1;
    logic [23:0] prev_data;

    // Bench-side cache model
    bit          m_valid = 0;
    logic [18:0] m_addr  = '0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: all output checking happens here, away from the active edge.
    always @(negedge Clk) begin
        if (mon_en) begin
            chk("we_n", {31'd0, SRAM_WE_N}, 32'd1);
            if (!SRAM_CE_N) begin
                chk("sram_ctl_on", {29'd0, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 32'd0);
                if (sram_q.size() == 0) fail_now("sram_unexpected_access");
                else chk("sram_addr", {12'd0, SRAM_ADDR}, {12'd0, sram_q.pop_front()});
            end else begin
                chk("sram_ctl_off", {29'd0, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 32'd7);
                chk("sram_addr_idle", {12'd0, SRAM_ADDR}, 32'd0);
            end

            if (busy) chk("ready_busy", {31'd0, Req_Ready}, 32'd0);

            if (Rsp_Valid) begin
                if (sbq.size() == 0) fail_now("unexpected_rsp");
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("data", {8'd0, Data_Out}, {8'd0, e.data});
                    chk("transp", {31'd0, Transparent}, {31'd0, e.transp});
                    if (accq.size() == 0) fail_now("rsp_without_accept");
                    else chk("latency", cyc + 1 - accq.pop_front(), e.lat);
                end
                rsp_log.push_back(cyc + 1);
                busy = 0;
            end else if (!skip) begin
                chk("hold", {8'd0, Data_Out}, {8'd0, prev_data});
            end
            prev_data = Data_Out;
            skip = 0;

            if (Reset) begin
                accq.delete();
                busy = 0;
                skip = 1;
            end else if (Req_Valid && Req_Ready) begin
                accq.push_back(cyc + 1);
                acc_log.push_back(cyc + 1);
                busy = 1;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!Req_Ready && n < 40) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!Req_Ready) fail_now("ready_timeout");
    endtask

    // Present one request (Req_Valid left high if hold) and queue expectations.
    task automatic issue(input logic [19:0] a, input logic [23:0] d, input bit hold);
        bit hit;
        wait_ready();
        Req_Valid = 1'b1;
        Req_Addr  = a;
        hit = 0;
`ifdef SPRITE_CACHE_EN
        hit = m_valid && (m_addr == a[18:0]);
        m_valid = 1;
        m_addr  = a[18:0];
`endif
        sbq.push_back('{data: d, transp: (d == 24'h0), lat: (hit ? 1 : 3)});
        if (!hit) begin
            sram_q.push_back({a[18:0], 1'b0});
            sram_q.push_back({a[18:0], 1'b1});
        end
        @(posedge Clk); #1;
        if (!hold) Req_Valid = 1'b0;
    endtask

    initial begin
        int base_acc, base_rsp, n;
        Reset     = 1'b1;
        Req_Valid = 1'b0;
        Req_Addr  = '0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("rst_ready", {31'd0, Req_Ready}, 32'd1);
        chk("rst_rsp", {31'd0, Rsp_Valid}, 32'd0);
        chk("rst_data", {8'd0, Data_Out}, 32'd0);
        chk("rst_transp", {31'd0, Transparent}, 32'd1);
        chk("rst_ce", {31'd0, SRAM_CE_N}, 32'd1);
        mon_en = 1;

        issue(20'h00010, 24'hF8A033, 0);
        issue(20'h00010, 24'hF8A033, 0);   // hit when cache built in
        issue(20'h00020, 24'h000000, 0);   // all-zero pixel

        // Req_Valid held high across three back-to-back requests
        wait_ready();
        base_acc = acc_log.size();
        base_rsp = rsp_log.size();
        issue(20'h00001, 24'h112244, 1);
        issue(20'h00002, 24'h556677, 1);
        issue(20'h00003, 24'h8899AA, 1);
        Req_Valid = 1'b0;
        wait_ready();
        @(posedge Clk); #1;
        if (acc_log.size() < base_acc + 1 || rsp_log.size() < base_rsp + 3)
            fail_now("held_stream_incomplete");
        else begin
            for (int i = 0; i < 3; i++)
                chk("held_rsp_cycle", rsp_log[base_rsp + i] - acc_log[base_acc], 3 + 4 * i);
        end

        issue(20'h80010, 24'hF8A033, 0);   // bit 19 ignored
        issue(20'hFFFFF, 24'hABCDEF, 0);   // top of address space
        issue(20'h00004, 24'h010203, 0);   // upper byte of low halfword ignored

        // Reset during RD_LO aborts the read
        wait_ready();
        Req_Valid = 1'b1;
        Req_Addr  = 20'h00005;
        sram_q.push_back(20'h0000A);
        sram_q.push_back(20'h0000B);
        @(posedge Clk); #1;                // now RD_HI
        Req_Valid = 1'b0;
        @(posedge Clk); #1;                // now RD_LO
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        m_valid = 0;
        chk("abort_data", {8'd0, Data_Out}, 32'd0);
        chk("abort_transp", {31'd0, Transparent}, 32'd1);
        chk("abort_ready", {31'd0, Req_Ready}, 32'd1);
        chk("abort_rsp", {31'd0, Rsp_Valid}, 32'd0);

        issue(20'h00010, 24'hF8A033, 0);   // misses again after reset
        issue(20'h00010, 24'hF8A033, 0);

        n = 0;
        while ((sbq.size() != 0 || sram_q.size() != 0) && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        if (sbq.size() != 0) fail_now("missing_responses");
        if (sram_q.size() != 0) fail_now("missing_sram_accesses");
        repeat (3) @(posedge Clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
